// File: rtl/keypad_password_entry_pkg.sv
// Shared definitions for the keypad password entry path: key codes,
// scanner state encoding and the row/column to key-code map.
package keypad_password_entry_pkg;

    localparam logic [3:0] KEY_BKSP      = 4'hD;
    localparam logic [3:0] KEY_CLR       = 4'hE;
    localparam logic [3:0] KEY_ENT       = 4'hF;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] COL_IDLE      = 4'hF;
    localparam logic [2:0] CNT_FULL      = 3'd4;
    localparam int         MAX_DIGITS    = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } scan_state_t;

    // Nibble {row,col} holds the key code:
    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_TABLE[{row, col, 2'b00} +: 4];
    endfunction

    // With several columns pulled low, the lowest-index column wins.
    function automatic logic [1:0] first_low_col(input logic [3:0] col);
        if (!col[0])
            return 2'd0;
        else if (!col[1])
            return 2'd1;
        else if (!col[2])
            return 2'd2;
        else
            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_password_entry_scanner.sv
// Matrix keypad scanner: synchronises the column inputs, divides the clock
// down to a scan tick, walks the rows, debounces press and release and
// decodes one key event per press.
module keypad_password_entry_scanner
    import keypad_password_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] REL_LAST  = DW'(DEBOUNCE_TICKS - 1);

    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    logic [TW-1:0] tick_cnt;
    logic          scan_tick;
    scan_state_t   state;
    logic [1:0]    row_sel;
    logic [1:0]    next_row;
    logic [3:0]    col_lat;
    logic [DW-1:0] deb_cnt;

    assign scan_tick = (tick_cnt == TICK_LAST);
    assign next_row  = row_sel + 2'd1;

    // Two-flop synchroniser for the asynchronous column lines; idle is all-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta <= COL_IDLE;
            col_sync <= COL_IDLE;
        end else begin
            col_meta <= key_col;
            col_sync <= col_meta;
        end
    end

    // Free-running scan divider; scan_tick marks its last count.
    always_ff @(posedge clk) begin
        if (rst)
            tick_cnt <= '0;
        else if (scan_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Scan/debounce/release FSM; every decision is taken on a scan tick only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            row_sel   <= 2'd0;
            key_row   <= 4'b1110;
            col_lat   <= COL_IDLE;
            deb_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            key_valid <= 1'b0;
            if (scan_tick) begin
                case (state)
                    ST_SCAN: begin
                        if (col_sync != COL_IDLE) begin
                            col_lat <= col_sync;
                            deb_cnt <= DW'(1);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            row_sel <= next_row;
                            key_row <= ~(4'b0001 << next_row);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (col_sync == col_lat) begin
                            if (deb_cnt == DEB_LAST) begin
                                key_code  <= key_lookup(row_sel, first_low_col(col_lat));
                                key_valid <= 1'b1;
                                deb_cnt   <= '0;
                                state     <= ST_RELEASE;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_RELEASE: begin
                        if (col_sync == COL_IDLE) begin
                            if (deb_cnt == REL_LAST) begin
                                deb_cnt <= '0;
                                state   <= ST_SCAN;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                    default: begin
                        deb_cnt <= '0;
                        state   <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_password_entry.sv
// Password entry top level: keypad scanner plus the four-digit entry buffer
// with backspace, clear and enter handling.
module keypad_password_entry
    import keypad_password_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [3:0]  p0,
    output logic [3:0]  p1,
    output logic [3:0]  p2,
    output logic [3:0]  p3,
    output logic [3:0]  digit_valid,
    output logic [2:0]  digit_cnt,
    output logic        pwd_valid,
    output logic [15:0] pwd,
    output logic        entry_err
);

    logic [3:0] p_buf [MAX_DIGITS];
    logic [1:0] wr_idx;
    logic [1:0] bk_idx;

    keypad_password_entry_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    assign p0     = p_buf[0];
    assign p1     = p_buf[1];
    assign p2     = p_buf[2];
    assign p3     = p_buf[3];
    assign wr_idx = digit_cnt[1:0];
    assign bk_idx = digit_cnt[1:0] - 2'd1;

    // Entry buffer: applies the decoded key one clock after key_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DIGITS; i++)
                p_buf[i] <= 4'h0;
            digit_valid <= 4'b0000;
            digit_cnt   <= 3'd0;
            pwd_valid   <= 1'b0;
            pwd         <= 16'h0000;
            entry_err   <= 1'b0;
        end else begin
            pwd_valid <= 1'b0;
            entry_err <= 1'b0;
            if (key_valid) begin
                if (key_code <= KEY_MAX_DIGIT) begin
                    if (digit_cnt < CNT_FULL) begin
                        p_buf[wr_idx]       <= key_code;
                        digit_valid[wr_idx] <= 1'b1;
                        digit_cnt           <= digit_cnt + 3'd1;
                    end
                end else if (key_code == KEY_BKSP) begin
                    if (digit_cnt != 3'd0) begin
                        p_buf[bk_idx]       <= 4'h0;
                        digit_valid[bk_idx] <= 1'b0;
                        digit_cnt           <= digit_cnt - 3'd1;
                    end
                end else if (key_code == KEY_CLR) begin
                    for (int i = 0; i < MAX_DIGITS; i++)
                        p_buf[i] <= 4'h0;
                    digit_valid <= 4'b0000;
                    digit_cnt   <= 3'd0;
                end else if (key_code == KEY_ENT) begin
                    if (digit_cnt == CNT_FULL) begin
                        pwd       <= {p_buf[3], p_buf[2], p_buf[1], p_buf[0]};
                        pwd_valid <= 1'b1;
                        for (int i = 0; i < MAX_DIGITS; i++)
                            p_buf[i] <= 4'h0;
                        digit_valid <= 4'b0000;
                        digit_cnt   <= 3'd0;
                    end else begin
                        entry_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
